// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the fifo write port.
// NREQ producers use req/gnt handshakes. The owner's words pass straight through to fifo din/wr_en.
// Each ownership lasts at most BURST words. Writes stall while the fifo is full.
module fifo_wr_arbiter #(
    parameter int unsigned IW    = 2,
    parameter int unsigned DW    = 16,
    parameter int unsigned BURST = 4,
    parameter int unsigned CW    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [(2**IW)-1:0]       req,
    input  logic [(2**IW)*DW-1:0]    din_bus,
    input  logic                     fifo_full,
    output logic [(2**IW)-1:0]       gnt,
    output logic [DW-1:0]            fifo_din,
    output logic                     fifo_wr_en,
    output logic [IW-1:0]            owner,
    output logic                     busy,
    output logic [CW-1:0]            wr_count
);

    localparam int unsigned NREQ    = 2**IW;
    localparam logic [7:0]  BURST_L = 8'(BURST);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] owner_nxt;
    logic [IW-1:0] last, last_nxt;
    logic [IW-1:0] base, pick, idx;
    logic [7:0]    burst_cnt, burst_nxt;
    logic [CW-1:0] wr_count_nxt;
    logic          found;
    logic          any_req;
    logic          exit_own;

    // Rotating pick: scan base+1, base+2, ... so the previous owner is checked last.
    // While OWN, the base is the current owner because an exit sets last=owner on the same edge.
    always_comb begin
        base  = (state == OWN) ? owner : last;
        pick  = base;
        idx   = base;
        found = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = base + IW'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Zero-latency write datapath: only the owner can be granted, and only when the fifo has room.
    always_comb begin
        gnt = '0;
        if ((state == OWN) && req[owner] && !fifo_full) begin
            gnt[owner] = 1'b1;
        end
        fifo_wr_en = |gnt;
        fifo_din   = fifo_wr_en ? din_bus[owner*DW +: DW] : '0;
        busy       = (state == OWN);
    end

    // Next-state logic: ownership, burst accounting and the rotation decision.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_nxt     = last;
        burst_nxt    = burst_cnt;
        wr_count_nxt = wr_count;
        any_req      = |req;
        exit_own     = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = OWN;
                    owner_nxt = pick;
                    burst_nxt = '0;
                end
            end
            OWN: begin
                if (fifo_wr_en) begin
                    burst_nxt    = burst_cnt + 8'd1;
                    wr_count_nxt = wr_count + CW'(1);
                end
                // A dropped req ends ownership even while the fifo is full.
                exit_own = !req[owner] || (fifo_wr_en && ((burst_cnt + 8'd1) == BURST_L));
                if (exit_own) begin
                    last_nxt  = owner;
                    burst_nxt = '0;
                    if (any_req) begin
                        owner_nxt = pick;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= '0;
            last      <= '1;
            burst_cnt <= '0;
            wr_count  <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_nxt;
            wr_count  <= wr_count_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter.
// A second instance with CW=4 receives the same stimulus and checks counter wrap.
module tb_fifo_wr_arbiter;

    localparam int unsigned IW = 2;
    localparam int unsigned DW = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     req;
    logic [63:0]    din_bus;
    logic           fifo_full;
    logic [DW-1:0]  dat [4];

    logic [3:0]     gnt, gnt2;
    logic [DW-1:0]  fifo_din, fifo_din2;
    logic           fifo_wr_en, fifo_wr_en2;
    logic [IW-1:0]  owner, owner2;
    logic           busy, busy2;
    logic [15:0]    wr_count;
    logic [3:0]     wr_count2;

    int total = 0;
    int bad   = 0;
    int cnt [4];
    int eo;

    assign din_bus = {dat[3], dat[2], dat[1], dat[0]};

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.IW(IW), .DW(DW), .BURST(4), .CW(16)) dut (
        .clk(clk), .reset(reset), .req(req), .din_bus(din_bus), .fifo_full(fifo_full),
        .gnt(gnt), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .owner(owner),
        .busy(busy), .wr_count(wr_count)
    );

    fifo_wr_arbiter #(.IW(IW), .DW(DW), .BURST(4), .CW(4)) dut_small (
        .clk(clk), .reset(reset), .req(req), .din_bus(din_bus), .fifo_full(fifo_full),
        .gnt(gnt2), .fifo_din(fifo_din2), .fifo_wr_en(fifo_wr_en2), .owner(owner2),
        .busy(busy2), .wr_count(wr_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        req       = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) dat[i] = '0;
        #3;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_din", 32'(fifo_din), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        tick;
        reset = 1'b1;

        // Single producer 2 writing three words
        dat[2] = 16'h0055;
        req    = 4'b0100;
        #2;
        chk("t2_idle_busy", 32'(busy), 0);
        chk("t2_idle_gnt", 32'(gnt), 0);
        tick;
        #1;
        chk("t2_busy", 32'(busy), 1);
        chk("t2_owner", 32'(owner), 2);
        chk("t2_gnt0", 32'(gnt), 32'h4);
        chk("t2_wr_en", 32'(fifo_wr_en), 1);
        chk("t2_din0", 32'(fifo_din), 32'h55);
        tick;
        dat[2] = 16'h0017;
        #1;
        chk("t2_gnt1", 32'(gnt), 32'h4);
        chk("t2_din1", 32'(fifo_din), 32'h17);
        tick;
        dat[2] = 16'h00AA;
        #1;
        chk("t2_gnt2", 32'(gnt), 32'h4);
        chk("t2_din2", 32'(fifo_din), 32'hAA);
        tick;
        req = '0;
        #1;
        chk("t2_wr_count", 32'(wr_count), 3);
        chk("t2_gnt_off", 32'(gnt), 0);
        tick;
        #1;
        chk("t2_idle_after", 32'(busy), 0);

        // Reset asserted mid-run
        req    = 4'b0010;
        dat[1] = 16'h1234;
        tick;
        #1;
        chk("t1_gnt", 32'(gnt), 32'h2);
        chk("t1_wr_en", 32'(fifo_wr_en), 1);
        tick;
        #1;
        chk("t1_wr_count_pre", 32'(wr_count), 4);
        #2;
        reset = 1'b0;
        #1;
        chk("t1_gnt_rst", 32'(gnt), 0);
        chk("t1_wr_en_rst", 32'(fifo_wr_en), 0);
        chk("t1_din_rst", 32'(fifo_din), 0);
        chk("t1_busy_rst", 32'(busy), 0);
        chk("t1_wr_count_rst", 32'(wr_count), 0);
        req = '0;
        tick;
        reset = 1'b1;

        // All producers requesting: 4-word bursts rotating 0,1,2,3 with no bubbles
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            dat[i] = 16'(i << 12);
        end
        req = 4'b1111;
        tick;
        for (int k = 0; k < 16; k++) begin
            #1;
            eo = k / 4;
            chk("t3_owner", 32'(owner), 32'(eo));
            chk("t3_gnt", 32'(gnt), 32'(1 << eo));
            chk("t3_wr_en", 32'(fifo_wr_en), 1);
            chk("t3_din", 32'(fifo_din), 32'((eo << 12) | (k % 4)));
            tick;
            cnt[eo]++;
            dat[eo] = 16'((eo << 12) | cnt[eo]);
        end
        req = '0;
        #1;
        chk("t3_wr_count", 32'(wr_count), 16);
        chk("t3_small_wrap", 32'(wr_count2), 0);
        chk("t3_owner_wrap", 32'(owner), 0);
        tick;
        #1;
        chk("t3_idle", 32'(busy), 0);

        // Producer 1 stalled by fifo_full mid-burst, with producer 2 waiting
        dat[1] = 16'hA001;
        dat[2] = 16'hB001;
        req    = 4'b0110;
        tick;
        #1;
        chk("t4_owner", 32'(owner), 1);
        chk("t4_gnt_w1", 32'(gnt), 32'h2);
        chk("t4_din_w1", 32'(fifo_din), 32'hA001);
        tick;
        dat[1] = 16'hA002;
        #1;
        chk("t4_din_w2", 32'(fifo_din), 32'hA002);
        tick;
        dat[1]    = 16'hA003;
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t4_full_gnt", 32'(gnt), 0);
            chk("t4_full_wr_en", 32'(fifo_wr_en), 0);
            chk("t4_full_owner", 32'(owner), 1);
            chk("t4_full_busy", 32'(busy), 1);
            tick;
        end
        fifo_full = 1'b0;
        #1;
        chk("t4_full_count", 32'(wr_count), 18);
        chk("t4_gnt_w3", 32'(gnt), 32'h2);
        chk("t4_din_w3", 32'(fifo_din), 32'hA003);
        tick;
        dat[1] = 16'hA004;
        #1;
        chk("t4_din_w4", 32'(fifo_din), 32'hA004);
        tick;
        #1;
        chk("t4_rot_owner", 32'(owner), 2);
        chk("t4_rot_gnt", 32'(gnt), 32'h4);
        chk("t4_rot_din", 32'(fifo_din), 32'hB001);
        chk("t4_wr_count", 32'(wr_count), 20);
        req = '0;
        tick;
        #1;
        chk("t4_idle", 32'(busy), 0);

        // Rotation fairness: owner 3 bursts, then 0 (3 checked last), then 3 again
        dat[3] = 16'hC000;
        dat[0] = 16'hD000;
        req    = 4'b1001;
        tick;
        #1;
        chk("t5_owner3", 32'(owner), 3);
        for (int k = 0; k < 4; k++) begin
            chk("t5_gnt3", 32'(gnt), 32'h8);
            chk("t5_din3", 32'(fifo_din), 32'(16'hC000 | k));
            tick;
            dat[3] = 16'(16'hC000 | (k + 1));
            #1;
        end
        chk("t5_owner0", 32'(owner), 0);
        chk("t5_gnt0", 32'(gnt), 32'h1);
        chk("t5_din0", 32'(fifo_din), 32'hD000);
        chk("t5_count24", 32'(wr_count), 24);
        tick;
        req = 4'b1000;
        #1;
        chk("t5_drop_gnt", 32'(gnt), 0);
        chk("t5_drop_busy", 32'(busy), 1);
        chk("t5_count25", 32'(wr_count), 25);
        tick;
        #1;
        chk("t5_back_owner", 32'(owner), 3);
        chk("t5_back_gnt", 32'(gnt), 32'h8);
        chk("t5_back_din", 32'(fifo_din), 32'hC004);
        tick;
        req = '0;
        #1;
        chk("t5_count26", 32'(wr_count), 26);
        tick;
        #1;
        chk("t5_idle", 32'(busy), 0);

        // Counter wrap on the CW=4 instance: 17 words from a single producer
        reset = 1'b0;
        #1;
        chk("t6_rst_small", 32'(wr_count2), 0);
        tick;
        reset  = 1'b1;
        dat[1] = 16'hE000;
        req    = 4'b0010;
        tick;
        for (int k = 0; k < 17; k++) begin
            #1;
            chk("t6_gnt", 32'(gnt), 32'h2);
            if (k == 16) begin
                chk("t6_small_16", 32'(wr_count2), 0);
            end
            tick;
            dat[1] = 16'(16'hE000 | (k + 1));
        end
        req = '0;
        #1;
        chk("t6_count17", 32'(wr_count), 17);
        chk("t6_small_wrap", 32'(wr_count2), 1);
        tick;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
